// File: rtl/alu_sekuencer.sv
// Sequencer driving a 16-bit ripple ALU: valid/ready request in, ALU controls out, valid/ready result back.
// Optional Zero/Ovf result flags are enabled by defining ALU_SEKUENCER_FLAGS_EN.
module alu_sekuencer #(
   parameter int unsigned W     = 16,
   parameter int unsigned CNT_W = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic [2:0]       OpKodi,
   input  logic [W-1:0]     OpA,
   input  logic [W-1:0]     OpB,
   output logic [W-1:0]     AluA,
   output logic [W-1:0]     AluB,
   output logic [2:0]       Operacion,
   output logic             BInvert,
   output logic             CIN,
   input  logic [W-1:0]     AluRez,
   input  logic             AluCOUT,
   output logic             OutValid,
   input  logic             OutReady,
`ifdef ALU_SEKUENCER_FLAGS_EN
   output logic             Zero,
   output logic             Ovf,
`endif
   output logic [W-1:0]     Rezultati
);

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_ADD  = 3'b011;
   localparam logic [2:0] OP_SUB  = 3'b100;
   localparam logic [2:0] OP_SLT  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_RSVD = 3'b111;

   localparam logic [2:0] SEL_AND  = 3'b000;
   localparam logic [2:0] SEL_LESS = 3'b001;
   localparam logic [2:0] SEL_OR   = 3'b010;
   localparam logic [2:0] SEL_XOR  = 3'b011;
   localparam logic [2:0] SEL_ADD  = 3'b100;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_MUL  = 2'b10,
      S_DONE = 2'b11
   } state_t;

   // {Operacion, BInvert, CIN} for a single-cycle opcode
   function automatic logic [4:0] ctrl_of(input logic [2:0] op);
      logic [4:0] c;
      c = 5'b0;
      case (op)
         OP_AND:  c = {SEL_AND,  1'b0, 1'b0};
         OP_OR:   c = {SEL_OR,   1'b0, 1'b0};
         OP_XOR:  c = {SEL_XOR,  1'b0, 1'b0};
         OP_ADD:  c = {SEL_ADD,  1'b0, 1'b0};
         OP_SUB:  c = {SEL_ADD,  1'b1, 1'b1};
         OP_SLT:  c = {SEL_LESS, 1'b1, 1'b1};
         default: c = 5'b0;
      endcase
      return c;
   endfunction

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [W-1:0]     opa_q, opa_d;
   logic [W-1:0]     opb_q, opb_d;
   logic [W-1:0]     acc_q, acc_d;
   logic [W-1:0]     mcand_q, mcand_d;
   logic [W-1:0]     mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     alu_a_q, alu_a_d;
   logic [W-1:0]     alu_b_q, alu_b_d;
   logic [2:0]       oper_q, oper_d;
   logic             binv_q, binv_d;
   logic             cin_q, cin_d;
   logic [W-1:0]     rez_q, rez_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;

   logic             accept;
   logic             out_hs;
   logic [W-1:0]     acc_next;
   logic [W-1:0]     mcand_shl;
   logic [W-1:0]     exec_val;

   // The ripple carry-out is not needed: overflow is derived from operand/result sign bits
   logic             unused_cout;
   assign unused_cout = AluCOUT;

   assign accept    = InValid && in_ready_q;
   assign out_hs    = out_valid_q && OutReady;
   assign acc_next  = mplier_q[0] ? AluRez : acc_q;
   assign mcand_shl = mcand_q << 1;
   assign exec_val  = (op_q == OP_RSVD) ? '0 : AluRez;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      rez_d    = rez_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      alu_a_d  = '0;
      alu_b_d  = '0;
      oper_d   = 3'b000;
      binv_d   = 1'b0;
      cin_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d  = OpKodi;
               opa_d = OpA;
               opb_d = OpB;
               if (OpKodi == OP_MUL) begin
                  state_d  = S_MUL;
                  acc_d    = '0;
                  mcand_d  = OpA;
                  mplier_d = OpB;
                  cnt_d    = '0;
                  alu_a_d  = '0;
                  alu_b_d  = OpA;
                  oper_d   = SEL_ADD;
               end else begin
                  state_d = S_EXEC;
                  alu_a_d = OpA;
                  alu_b_d = OpB;
                  {oper_d, binv_d, cin_d} = ctrl_of(OpKodi);
               end
            end
         end
         S_EXEC: begin
            state_d = S_DONE;
            rez_d   = exec_val;
            zero_d  = (exec_val == '0);
            ovf_d   = 1'b0;
            if (op_q == OP_ADD)
               ovf_d = (opa_q[W-1] == opb_q[W-1]) && (AluRez[W-1] != opa_q[W-1]);
            else if (op_q == OP_SUB)
               ovf_d = (opa_q[W-1] != opb_q[W-1]) && (AluRez[W-1] != opa_q[W-1]);
         end
         S_MUL: begin
            // Shift-add step: the ALU is presenting acc + mcand this cycle
            acc_d    = acc_next;
            mcand_d  = mcand_shl;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               rez_d   = acc_next;
               zero_d  = (acc_next == '0);
               ovf_d   = 1'b0;
            end else begin
               alu_a_d = acc_next;
               alu_b_d = mcand_shl;
               oper_d  = SEL_ADD;
            end
         end
         S_DONE: begin
            if (out_hs)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // OutValid rises one cycle into DONE so Rezultati has settled a full cycle beforehand
      out_valid_d = (state_q == S_DONE) && !out_hs;
      in_ready_d  = (state_d == S_IDLE);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         oper_q      <= '0;
         binv_q      <= 1'b0;
         cin_q       <= 1'b0;
         rez_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         cnt_q       <= cnt_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         oper_q      <= oper_d;
         binv_q      <= binv_d;
         cin_q       <= cin_d;
         rez_q       <= rez_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
      end
   end

   assign InReady   = in_ready_q;
   assign OutValid  = out_valid_q;
   assign Rezultati = rez_q;
   assign AluA      = alu_a_q;
   assign AluB      = alu_b_q;
   assign Operacion = oper_q;
   assign BInvert   = binv_q;
   assign CIN       = cin_q;

`ifdef ALU_SEKUENCER_FLAGS_EN
   assign Zero = zero_q;
   assign Ovf  = ovf_q;
`else
   logic unused_flags;
   assign unused_flags = zero_q ^ ovf_q;
`endif

endmodule

// File: tb/tb_alu_sekuencer.sv
// Directed bench for alu_sekuencer with a behavioural 16-bit slice ALU closing the loop.
module tb_alu_sekuencer;

   localparam int unsigned W = 16;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          InValid;
   logic          InReady;
   logic [2:0]    OpKodi;
   logic [W-1:0]  OpA, OpB;
   logic [W-1:0]  AluA, AluB;
   logic [2:0]    Operacion;
   logic          BInvert, CIN;
   logic [W-1:0]  AluRez;
   logic          AluCOUT;
   logic          OutValid;
   logic          OutReady;
   logic [W-1:0]  Rezultati;
`ifdef ALU_SEKUENCER_FLAGS_EN
   logic          Zero, Ovf;
`endif

   int total = 0;
   int bad   = 0;

   alu_sekuencer #(.W(W), .CNT_W(4)) dut (
      .Clock(Clock), .Reset(Reset),
      .InValid(InValid), .InReady(InReady),
      .OpKodi(OpKodi), .OpA(OpA), .OpB(OpB),
      .AluA(AluA), .AluB(AluB), .Operacion(Operacion),
      .BInvert(BInvert), .CIN(CIN),
      .AluRez(AluRez), .AluCOUT(AluCOUT),
      .OutValid(OutValid), .OutReady(OutReady),
`ifdef ALU_SEKUENCER_FLAGS_EN
      .Zero(Zero), .Ovf(Ovf),
`endif
      .Rezultati(Rezultati)
   );

   always #5 Clock = ~Clock;

   // Ripple ALU: LESS places the adder sign bit into bit 0
   logic [W-1:0] bb;
   logic [W:0]   sum;
   always_comb begin
      bb      = BInvert ? ~AluB : AluB;
      sum     = (W+1)'(AluA) + (W+1)'(bb) + (W+1)'(CIN);
      AluCOUT = sum[W];
      case (Operacion)
         3'b000:  AluRez = AluA & bb;
         3'b001:  AluRez = {{(W-1){1'b0}}, sum[W-1]};
         3'b010:  AluRez = AluA | bb;
         3'b011:  AluRez = AluA ^ bb;
         3'b100:  AluRez = sum[W-1:0];
         default: AluRez = '0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Issue one request and wait for OutValid; the result is left pending
   task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp,
                        input int exp_lat, input logic [4:0] exp_ctrl);
      int   lat;
      logic rdy_seen;
      @(negedge Clock);
      chk({tag, "_in_ready"}, InReady, 1);
      InValid = 1'b1; OpKodi = op; OpA = a; OpB = b;
      @(posedge Clock);
      @(negedge Clock);
      InValid = 1'b0;
      chk({tag, "_ctrl"}, {Operacion, BInvert, CIN}, exp_ctrl);
      chk({tag, "_alu_a"}, AluA, (op == 3'b110) ? 16'h0 : a);
      lat = 0;
      rdy_seen = 1'b0;
      while (!OutValid && lat < 40) begin
         if (InReady) rdy_seen = 1'b1;
         @(posedge Clock);
         @(negedge Clock);
         lat++;
      end
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_busy_ready"}, rdy_seen, 0);
      chk({tag, "_result"}, Rezultati, exp);
   endtask

   task automatic consume(input string tag);
      OutReady = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      OutReady = 1'b0;
      chk({tag, "_valid_drop"}, OutValid, 0);
      chk({tag, "_ready_back"}, InReady, 1);
   endtask

   initial begin
      Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
      OpKodi = 3'b000; OpA = '0; OpB = '0;
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      chk("rst_in_ready", InReady, 1);
      chk("rst_out_valid", OutValid, 0);
      chk("rst_rez", Rezultati, 0);
      chk("rst_alu", {AluA, AluB, Operacion, BInvert, CIN}, 0);
      Reset = 1'b0;

      do_op("add_ovf", 3'b011, 16'h7FFF, 16'h0001, 16'h8000, 2, 5'b10000);
`ifdef ALU_SEKUENCER_FLAGS_EN
      chk("add_ovf_flag", Ovf, 1);
      chk("add_zero_flag", Zero, 0);
`endif
      consume("add_ovf");
      chk("idle_alu", {AluA, AluB, Operacion, BInvert, CIN}, 0);

      do_op("sub_zero", 3'b100, 16'h0005, 16'h0005, 16'h0000, 2, 5'b10011);
`ifdef ALU_SEKUENCER_FLAGS_EN
      chk("sub_zero_flag", Zero, 1);
      chk("sub_ovf_flag", Ovf, 0);
`endif
      consume("sub_zero");

      do_op("slt_true", 3'b101, 16'hFFFE, 16'h0001, 16'h0001, 2, 5'b00111);
      consume("slt_true");
      do_op("slt_false", 3'b101, 16'h0003, 16'h0002, 16'h0000, 2, 5'b00111);
      consume("slt_false");
      do_op("or", 3'b001, 16'hA000, 16'h000A, 16'hA00A, 2, 5'b01000);
      consume("or");
      do_op("xor", 3'b010, 16'hFF00, 16'h0FF0, 16'hF0F0, 2, 5'b01100);
      consume("xor");

      do_op("mul_a", 3'b110, 16'h0123, 16'h0010, 16'h1230, 17, 5'b10000);
      consume("mul_a");
      do_op("mul_b", 3'b110, 16'hFFFF, 16'hFFFF, 16'h0001, 17, 5'b10000);

      // Result held while OutReady is low; new requests must be refused
      OpKodi = 3'b000; OpA = 16'h1111; OpB = 16'h2222;
      for (int i = 0; i < 5; i++) begin
         InValid = (i % 2 == 0);
         @(posedge Clock);
         @(negedge Clock);
         chk("hold_valid", OutValid, 1);
         chk("hold_rez", Rezultati, 16'h0001);
         chk("hold_ready", InReady, 0);
      end
      InValid = 1'b0;
      consume("mul_b");

      // Reset while the multiply loop is at cnt=7
      @(negedge Clock);
      InValid = 1'b1; OpKodi = 3'b110; OpA = 16'h0123; OpB = 16'h0010;
      @(posedge Clock);
      @(negedge Clock);
      InValid = 1'b0;
      repeat (7) @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      chk("midrst_in_ready", InReady, 1);
      chk("midrst_out_valid", OutValid, 0);
      chk("midrst_rez", Rezultati, 0);
      chk("midrst_alu", {AluA, AluB, Operacion, BInvert, CIN}, 0);

      do_op("and", 3'b000, 16'hF0F0, 16'h0FF0, 16'h00F0, 2, 5'b00000);
      consume("and");
      do_op("rsvd", 3'b111, 16'h1234, 16'h5678, 16'h0000, 2, 5'b00000);
      consume("rsvd");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
